// File: rtl/multdiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encoding,
// exception redirection constants and the ready-qualification threshold.
package multdiv_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int RSTATUS_REG   = 30;
  localparam int MULT_EXC_CODE = 4;
  localparam int DIV_EXC_CODE  = 5;

  // The unit's ready flag is free-running and still reflects the previous op
  // for a couple of cycles after a start pulse.
  localparam int RDY_MIN_WAIT  = 2;

endpackage

// File: rtl/multdiv_op_latch.sv
// Holds the accepted operation (operands, destination, op kind) stable for
// the whole multi-cycle operation.
module multdiv_op_latch
  import multdiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int REG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in_opA,
  input  logic [WIDTH-1:0] in_opB,
  input  logic [REG_W-1:0] in_rd,
  input  logic             in_is_div,
  output logic [WIDTH-1:0] opA,
  output logic [WIDTH-1:0] opB,
  output logic [REG_W-1:0] rd,
  output logic             is_div
);

  localparam int N = 2 * WIDTH + REG_W + 1;

  logic [N-1:0] q_s;

  register_Nbit #(.N(N)) u_reg (
    .clock (clock),
    .reset (reset),
    .en    (load),
    .d     ({in_opA, in_opB, in_rd, in_is_div}),
    .q     (q_s)
  );

  assign {opA, opB, rd, is_div} = q_s;

endmodule

// File: rtl/register_Nbit.sv
// Generic N-bit register with load enable and synchronous clear.
module register_Nbit #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // storage with synchronous clear taking priority over load
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= {N{1'b0}};
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer between execute and the multi-cycle multiply/divide unit: issues
// the start pulse, stalls the pipe, qualifies ready and hands off to writeback.
module multdiv_ctrl #(
  parameter int WIDTH         = 32,
  parameter int REG_W         = 5,
  parameter int RSTATUS_REG   = multdiv_ctrl_pkg::RSTATUS_REG,
  parameter int MULT_EXC_CODE = multdiv_ctrl_pkg::MULT_EXC_CODE,
  parameter int DIV_EXC_CODE  = multdiv_ctrl_pkg::DIV_EXC_CODE,
  parameter int TIMEOUT       = 40
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_is_div,
  input  logic [WIDTH-1:0] in_opA,
  input  logic [WIDTH-1:0] in_opB,
  input  logic [REG_W-1:0] in_rd,
  input  logic             flush,
  output logic [WIDTH-1:0] md_operandA,
  output logic [WIDTH-1:0] md_operandB,
  output logic             md_ctrl_MULT,
  output logic             md_ctrl_DIV,
  input  logic [WIDTH-1:0] md_result,
  input  logic             md_exception,
  input  logic             md_resultRDY,
  output logic             stall,
  output logic             out_valid,
  output logic [REG_W-1:0] out_rd,
  output logic [WIDTH-1:0] out_result,
  output logic             out_exception
);

  import multdiv_ctrl_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             accept_s;
  logic             capture_s;
  logic             capture_exc_s;
  logic             qual_rdy_s;
  logic             timeout_s;
  logic [REG_W-1:0] rd_s;
  logic             is_div_s;
  logic             md_ctrl_mult_r;
  logic             md_ctrl_div_r;
  logic [REG_W-1:0] out_rd_r;
  logic [WIDTH-1:0] out_result_r;
  logic             out_exception_r;

  multdiv_op_latch #(.WIDTH(WIDTH), .REG_W(REG_W)) u_op_latch (
    .clock     (clock),
    .reset     (reset),
    .load      (accept_s),
    .in_opA    (in_opA),
    .in_opB    (in_opB),
    .in_rd     (in_rd),
    .in_is_div (in_is_div),
    .opA       (md_operandA),
    .opB       (md_operandB),
    .rd        (rd_s),
    .is_div    (is_div_s)
  );

  assign qual_rdy_s = md_resultRDY && (wait_cnt_r >= CNT_W'(RDY_MIN_WAIT));
  assign timeout_s  = (wait_cnt_r == CNT_W'(TIMEOUT - 1));

  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next state, stall and writeback strobe; flush outranks a qualified ready
  always_comb begin
    state_next_s  = state_r;
    accept_s      = 1'b0;
    capture_s     = 1'b0;
    capture_exc_s = 1'b0;
    stall         = 1'b0;
    out_valid     = 1'b0;
    case (state_r)
      S_IDLE: begin
        stall = in_valid;
        if (in_valid && !flush) begin
          accept_s     = 1'b1;
          state_next_s = S_ISSUE;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        stall = !flush;
        if (flush) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_BUSY;
        end
      end
      S_BUSY: begin
        stall = !flush;
        if (flush) begin
          state_next_s = S_IDLE;
        end else if (qual_rdy_s) begin
          capture_s     = 1'b1;
          capture_exc_s = md_exception;
          state_next_s  = S_DONE;
        end else if (timeout_s) begin
          capture_s     = 1'b1;
          capture_exc_s = 1'b1;
          state_next_s  = S_DONE;
        end else begin
          state_next_s = S_BUSY;
        end
      end
      S_DONE: begin
        out_valid    = !flush;
        state_next_s = S_IDLE;
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // start pulses, wait counter and writeback capture
  always_ff @(posedge clock) begin
    if (reset) begin
      md_ctrl_mult_r  <= 1'b0;
      md_ctrl_div_r   <= 1'b0;
      wait_cnt_r      <= {CNT_W{1'b0}};
      out_rd_r        <= {REG_W{1'b0}};
      out_result_r    <= {WIDTH{1'b0}};
      out_exception_r <= 1'b0;
    end else begin
      md_ctrl_mult_r <= accept_s && !in_is_div;
      md_ctrl_div_r  <= accept_s && in_is_div;
      if (state_r == S_ISSUE) begin
        wait_cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == S_BUSY) begin
        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end
      if (capture_s) begin
        if (capture_exc_s) begin
          out_result_r    <= is_div_s ? WIDTH'(DIV_EXC_CODE) : WIDTH'(MULT_EXC_CODE);
          out_rd_r        <= REG_W'(RSTATUS_REG);
          out_exception_r <= 1'b1;
        end else begin
          out_result_r    <= md_result;
          out_rd_r        <= rd_s;
          out_exception_r <= 1'b0;
        end
      end
    end
  end

  assign md_ctrl_MULT  = md_ctrl_mult_r;
  assign md_ctrl_DIV   = md_ctrl_div_r;
  assign out_rd        = out_rd_r;
  assign out_result    = out_result_r;
  assign out_exception = out_exception_r;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: directed scenarios plus randomized
// operations checked against a cycle-count/arithmetic reference model.
module tb_multdiv_ctrl;

  localparam int WIDTH   = 32;
  localparam int REG_W   = 5;
  localparam int TIMEOUT = 40;
  // Accept at cycle 0, pulse at 1, first BUSY cycle at 2; timeout fires on
  // the BUSY cycle whose count is TIMEOUT-1.
  localparam int TO_CYC  = 2 + TIMEOUT - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_is_div;
  logic [WIDTH-1:0] in_opA;
  logic [WIDTH-1:0] in_opB;
  logic [REG_W-1:0] in_rd;
  logic             flush;
  logic [WIDTH-1:0] md_operandA;
  logic [WIDTH-1:0] md_operandB;
  logic             md_ctrl_MULT;
  logic             md_ctrl_DIV;
  logic [WIDTH-1:0] md_result;
  logic             md_exception;
  logic             md_resultRDY;
  logic             stall;
  logic             out_valid;
  logic [REG_W-1:0] out_rd;
  logic [WIDTH-1:0] out_result;
  logic             out_exception;

  int checks = 0;
  int errors = 0;

  logic [63:0]      obs_stall, obs_valid, obs_mult, obs_div;
  logic [WIDTH-1:0] obs_result;
  logic [REG_W-1:0] obs_rd;
  logic             obs_exc;
  int               obs_op_bad;
  logic             obs_zero;

  always #5 clock = ~clock;

  multdiv_ctrl #(.WIDTH(WIDTH), .REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_is_div     (in_is_div),
    .in_opA        (in_opA),
    .in_opB        (in_opB),
    .in_rd         (in_rd),
    .flush         (flush),
    .md_operandA   (md_operandA),
    .md_operandB   (md_operandB),
    .md_ctrl_MULT  (md_ctrl_MULT),
    .md_ctrl_DIV   (md_ctrl_DIV),
    .md_result     (md_result),
    .md_exception  (md_exception),
    .md_resultRDY  (md_resultRDY),
    .stall         (stall),
    .out_valid     (out_valid),
    .out_rd        (out_rd),
    .out_result    (out_result),
    .out_exception (out_exception)
  );

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] v;
    v = 64'd0;
    for (int i = lo; i <= hi; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] bit_at(input int c);
    logic [63:0] v;
    v = 64'd0;
    v[c] = 1'b1;
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] unit_result(input logic [WIDTH-1:0] a, b, input logic is_div);
    if (is_div) return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
    else        return a * b;
  endfunction

  // Drives one operation cycle by cycle (ready pulse, stale ready, flush,
  // reset at given cycles) and records what the DUT did; no judging here.
  task automatic do_op(input logic [WIDTH-1:0] a, b, input logic [REG_W-1:0] rd,
                       input logic is_div, input int rdy_cyc, input logic exc,
                       input int stale_to, input int flush_cyc, input int reset_cyc,
                       input logic hold_valid, input int budget);
    logic [WIDTH-1:0] res;
    res = unit_result(a, b, is_div);
    obs_stall = 64'd0; obs_valid = 64'd0; obs_mult = 64'd0; obs_div = 64'd0;
    obs_result = 32'd0; obs_rd = 5'd0; obs_exc = 1'b0; obs_op_bad = 0; obs_zero = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      in_valid     = (c == 0) || hold_valid;
      in_is_div    = (c == 0) ? is_div : 1'($urandom_range(0, 1));
      in_opA       = (c == 0) ? a : $urandom;
      in_opB       = (c == 0) ? b : $urandom;
      in_rd        = (c == 0) ? rd : 5'($urandom);
      md_resultRDY = (c == rdy_cyc) || (c >= 1 && c <= stale_to);
      md_result    = (c == rdy_cyc) ? res : $urandom;
      md_exception = (c == rdy_cyc) ? exc : 1'($urandom_range(0, 1));
      flush        = (c == flush_cyc);
      reset        = (c == reset_cyc);
      #1;
      obs_stall[c] = stall;
      obs_valid[c] = out_valid;
      obs_mult[c]  = md_ctrl_MULT;
      obs_div[c]   = md_ctrl_DIV;
      if (c >= 1 && (reset_cyc < 0 || c <= reset_cyc) &&
          (md_operandA !== a || md_operandB !== b)) obs_op_bad++;
      if (reset_cyc >= 0 && c == reset_cyc + 1)
        obs_zero = ({md_operandA, md_operandB, out_result, out_rd, out_exception,
                     md_ctrl_MULT, md_ctrl_DIV, out_valid, stall} === '0);
      if (out_valid === 1'b1) begin
        obs_result = out_result;
        obs_rd     = out_rd;
        obs_exc    = out_exception;
        break;
      end
    end
    in_valid = 1'b0; flush = 1'b0; reset = 1'b0; md_resultRDY = 1'b0; md_exception = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; in_is_div = 1'b0;
    in_opA = 32'd0; in_opB = 32'd0; in_rd = 5'd0;
    md_result = 32'd0; md_exception = 1'b0; md_resultRDY = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0; md_resultRDY = 1'b0;
    #1;
    checks++;
    if ({md_operandA, md_operandB, out_result, out_rd, out_exception,
         md_ctrl_MULT, md_ctrl_DIV, out_valid, stall} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: opA=%h opB=%h res=%h rd=%0d exc=%b mult=%b div=%b valid=%b stall=%b, required all 0",
               md_operandA, md_operandB, out_result, out_rd, out_exception,
               md_ctrl_MULT, md_ctrl_DIV, out_valid, stall);
    end
    // flush in IDLE: stall follows in_valid, but no acceptance
    @(negedge clock);
    in_valid = 1'b1; flush = 1'b1; in_opA = 32'd11; in_opB = 32'd12;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL idle_stall: stall=%b required 1", stall);
    end
    @(negedge clock);
    in_valid = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if ({stall, md_ctrl_MULT, md_ctrl_DIV} !== 3'b000) begin
      errors++;
      $display("FAIL idle_flush_block: stall/mult/div=%b required 000", {stall, md_ctrl_MULT, md_ctrl_DIV});
    end
  endtask

  task automatic test_mult_basic();
    do_op(32'd7, 32'd6, 5'd3, 1'b0, 17, 1'b0, 0, -1, -1, 1'b1, 30);
    checks++;
    if (obs_mult !== bit_at(1) || obs_div !== 64'd0) begin
      errors++; $display("FAIL mult_pulse: mult=%h div=%h required %h / 0", obs_mult, obs_div, bit_at(1));
    end
    checks++;
    if (obs_stall !== span(0, 17)) begin
      errors++; $display("FAIL mult_stall: got %h required %h", obs_stall, span(0, 17));
    end
    checks++;
    if (obs_valid !== bit_at(18)) begin
      errors++; $display("FAIL mult_valid: got %h required %h", obs_valid, bit_at(18));
    end
    checks++;
    if (obs_result !== 32'd42 || obs_rd !== 5'd3 || obs_exc !== 1'b0) begin
      errors++; $display("FAIL mult_data: res=%0d rd=%0d exc=%b required 42/3/0", obs_result, obs_rd, obs_exc);
    end
    checks++;
    if (obs_op_bad !== 0) begin
      errors++; $display("FAIL mult_operands: %0d unstable cycles, required 0", obs_op_bad);
    end
  endtask

  task automatic test_mult_exception();
    do_op(32'h4000_0000, 32'd4, 5'd9, 1'b0, 17, 1'b1, 0, -1, -1, 1'b1, 30);
    checks++;
    if (obs_valid !== bit_at(18)) begin
      errors++; $display("FAIL mexc_valid: got %h required %h", obs_valid, bit_at(18));
    end
    checks++;
    if (obs_result !== 32'd4 || obs_rd !== 5'd30 || obs_exc !== 1'b1) begin
      errors++; $display("FAIL mexc_data: res=%0d rd=%0d exc=%b required 4/30/1", obs_result, obs_rd, obs_exc);
    end
  endtask

  task automatic test_div_exception();
    do_op(32'd10, 32'd0, 5'd7, 1'b1, 12, 1'b1, 0, -1, -1, 1'b1, 30);
    checks++;
    if (obs_div !== bit_at(1) || obs_mult !== 64'd0) begin
      errors++; $display("FAIL div_pulse: div=%h mult=%h required %h / 0", obs_div, obs_mult, bit_at(1));
    end
    checks++;
    if (obs_valid !== bit_at(13) || obs_result !== 32'd5 || obs_rd !== 5'd30 || obs_exc !== 1'b1) begin
      errors++; $display("FAIL div_exc: valid=%h res=%0d rd=%0d exc=%b required %h/5/30/1",
                         obs_valid, obs_result, obs_rd, obs_exc, bit_at(13));
    end
  endtask

  task automatic test_stale_ready();
    do_op(32'd100, 32'd7, 5'd12, 1'b1, 9, 1'b0, 3, -1, -1, 1'b1, 30);
    checks++;
    if (obs_valid !== bit_at(10) || obs_result !== 32'd14 || obs_rd !== 5'd12) begin
      errors++; $display("FAIL stale_ready: valid=%h res=%0d rd=%0d required %h/14/12",
                         obs_valid, obs_result, obs_rd, bit_at(10));
    end
  endtask

  task automatic test_flush();
    do_op(32'd5, 32'd5, 5'd4, 1'b0, 17, 1'b0, 0, 7, -1, 1'b0, 9);
    checks++;
    if (obs_valid !== 64'd0 || obs_stall !== span(0, 6)) begin
      errors++; $display("FAIL flush_busy: valid=%h stall=%h required 0/%h", obs_valid, obs_stall, span(0, 6));
    end
    do_op(32'd3, 32'd3, 5'd8, 1'b0, 17, 1'b0, 0, -1, -1, 1'b1, 30);
    checks++;
    if (obs_valid !== bit_at(18) || obs_result !== 32'd9 || obs_rd !== 5'd8) begin
      errors++; $display("FAIL flush_next_op: valid=%h res=%0d rd=%0d required %h/9/8",
                         obs_valid, obs_result, obs_rd, bit_at(18));
    end
    do_op(32'd6, 32'd2, 5'd2, 1'b0, 10, 1'b0, 0, 11, -1, 1'b0, 14);
    checks++;
    if (obs_valid !== 64'd0 || obs_stall !== span(0, 10)) begin
      errors++; $display("FAIL flush_done: valid=%h stall=%h required 0/%h", obs_valid, obs_stall, span(0, 10));
    end
  endtask

  task automatic test_reset_mid_busy();
    do_op(32'd9, 32'd9, 5'd1, 1'b0, 17, 1'b0, 0, -1, 8, 1'b0, 25);
    checks++;
    if (obs_zero !== 1'b1) begin
      errors++; $display("FAIL reset_mid_zero: outputs after reset zero=%b required 1", obs_zero);
    end
    checks++;
    if (obs_valid !== 64'd0 || obs_stall !== span(0, 8)) begin
      errors++; $display("FAIL reset_mid_valid: valid=%h stall=%h required 0/%h", obs_valid, obs_stall, span(0, 8));
    end
  endtask

  task automatic test_timeout();
    do_op(32'd2, 32'd3, 5'd6, 1'b0, -1, 1'b0, 0, -1, -1, 1'b1, 50);
    checks++;
    if (obs_valid !== bit_at(TO_CYC + 1) || obs_result !== 32'd4 || obs_rd !== 5'd30 || obs_exc !== 1'b1) begin
      errors++; $display("FAIL timeout: valid=%h res=%0d rd=%0d exc=%b required %h/4/30/1",
                         obs_valid, obs_result, obs_rd, obs_exc, bit_at(TO_CYC + 1));
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b, exp_res;
    logic [REG_W-1:0] rd, exp_rd;
    logic             is_div, exc, exp_exc, timed_out;
    int               rdy, done, stale;
    for (int it = 0; it < 12; it++) begin
      a      = $urandom;
      is_div = 1'($urandom_range(0, 1));
      b      = is_div ? 32'($urandom_range(1, 1000)) : $urandom;
      rd     = 5'($urandom);
      exc    = ($urandom_range(0, 3) == 0);
      rdy    = $urandom_range(4, 46);
      stale  = $urandom_range(0, 3);
      timed_out = (rdy > TO_CYC);
      done    = (timed_out ? TO_CYC : rdy) + 1;
      exp_exc = timed_out || exc;
      exp_res = exp_exc ? (is_div ? 32'd5 : 32'd4) : unit_result(a, b, is_div);
      exp_rd  = exp_exc ? 5'd30 : rd;
      do_op(a, b, rd, is_div, rdy, exc, stale, -1, -1, 1'b1, 50);
      checks++;
      if (obs_valid !== bit_at(done) || obs_result !== exp_res || obs_rd !== exp_rd || obs_exc !== exp_exc) begin
        errors++;
        $display("FAIL random_%0d: valid=%h res=%h rd=%0d exc=%b required %h/%h/%0d/%b",
                 it, obs_valid, obs_result, obs_rd, obs_exc, bit_at(done), exp_res, exp_rd, exp_exc);
      end
      checks++;
      if (obs_mult !== (is_div ? 64'd0 : bit_at(1)) || obs_div !== (is_div ? bit_at(1) : 64'd0) ||
          obs_op_bad !== 0) begin
        errors++;
        $display("FAIL random_pulse_%0d: mult=%h div=%h op_bad=%0d", it, obs_mult, obs_div, obs_op_bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult_basic();
    test_mult_exception();
    test_div_exception();
    test_stale_ready();
    test_flush();
    test_reset_mid_busy();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Sequencer between the execute stage and the multi-cycle multiply/divide unit.
- Accepts one MULT or DIV op, latches its operands and destination, and holds the operands stable for the whole operation; the multiplier re-reads them every cycle.
- Issues a one-cycle ctrl_MULT or ctrl_DIV pulse, stalls the pipeline, and waits for a qualified resultRDY.
- Hands the result to writeback; on exception, redirects the write to the status register with the codebase exception code.

Parameters:
- WIDTH, 32, operand/result width.
- REG_W, 5, register address width.
- RSTATUS_REG, 30, destination register on exception.
- MULT_EXC_CODE, 4, value written on mult exception.
- DIV_EXC_CODE, 5, value written on div exception.
- TIMEOUT, 40, max BUSY cycles before forced completion.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  execute stage presents a MULT/DIV op
- in_is_div  in  1  1 = DIV, 0 = MULT
- in_opA  in  WIDTH  operand A (multiplicand/dividend)
- in_opB  in  WIDTH  operand B (multiplier/divisor)
- in_rd  in  REG_W  destination register
- flush  in  1  abort in-flight op (branch/exception squash)
- md_operandA  out  WIDTH  held operand A to unit
- md_operandB  out  WIDTH  held operand B to unit
- md_ctrl_MULT  out  1  start pulse, multiply
- md_ctrl_DIV  out  1  start pulse, divide
- md_result  in  WIDTH  unit result
- md_exception  in  1  unit exception
- md_resultRDY  in  1  unit ready (free-running; may be high when stale)
- stall  out  1  freeze upstream pipeline
- out_valid  out  1  writeback strobe, one cycle
- out_rd  out  REG_W  writeback register
- out_result  out  WIDTH  writeback data
- out_exception  out  1  completed op raised an exception

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE.
  - All registered outputs = 0: md_operand*, out_*, pulses.
  - wait_cnt = 0.
  - Reset mid-operation abandons the op with no out_valid; the unit's later resultRDY is ignored.
- States: IDLE, ISSUE, BUSY, DONE. 2-bit encoding in the package.
- IDLE:
  - If in_valid & ~flush: latch opA, opB, rd, is_div; go to ISSUE.
  - stall = in_valid (combinational, same cycle).
- ISSUE (exactly 1 cycle):
  - md_ctrl_MULT = ~is_div; md_ctrl_DIV = is_div.
  - wait_cnt cleared; go to BUSY.
  - stall = 1.
- BUSY:
  - wait_cnt increments every cycle.
  - md_resultRDY is qualified only when wait_cnt >= 2. This rejects the stale ready from the free-running counter before it clears.
  - On qualified ready, capture:
    - Normal: out_result = md_result, out_rd = rd, out_exception = 0.
    - On md_exception: out_result = MULT_EXC_CODE or DIV_EXC_CODE per is_div, out_rd = RSTATUS_REG, out_exception = 1.
    - Then go to DONE.
  - If wait_cnt reaches TIMEOUT-1 without ready: capture as exception; go to DONE.
  - stall = 1.
- DONE (1 cycle):
  - out_valid = 1; stall = 0.
  - in_valid is ignored: it is still the completing instruction.
  - Go to IDLE.
  - out_result, out_rd and out_exception hold their value until the next capture; out_valid is 0 outside DONE.
- Operand holding: md_operandA/B are driven from latched registers in every state and change only on IDLE acceptance.
- Flush:
  - In ISSUE or BUSY, flush forces IDLE next cycle; no out_valid; stall drops that cycle.
  - In DONE, flush suppresses out_valid (out_valid = 0).
  - In IDLE, flush blocks acceptance.
- Pulse rules: md_ctrl_MULT and md_ctrl_DIV are never high together and never high outside ISSUE.
- Latency: in_valid accepted at cycle 0 → pulse at cycle 1 → DONE at the qualified-ready cycle + 1. With the 16-cycle multiplier, out_valid is at cycle 18.
- Simultaneous events:
  - reset beats flush, which beats qualified ready.
  - Ready and TIMEOUT in the same cycle: ready wins.

Decomposition:
- Shared package holds:
  - the state encoding (S_IDLE=0, S_ISSUE=1, S_BUSY=2, S_DONE=3);
  - RSTATUS_REG, MULT_EXC_CODE, DIV_EXC_CODE;
  - the ready-qualification minimum (2).
- One natural sub-module: multdiv_op_latch. It is a WIDTH*2+REG_W+1 register with load enable and synchronous clear, built on register_Nbit.
- The FSM and wait counter stay in the top level.

Test Plan:
- MULT 7×6: in_valid 1 cycle, rd=3; model unit ready 16 cycles after pulse → one md_ctrl_MULT pulse at cycle 1; stall high cycles 0–17; out_valid at cycle 18 with out_result=42, out_rd=3, out_exception=0.
- MULT 0x40000000×4 with md_exception=1 at ready → out_rd=30, out_result=4, out_exception=1, single out_valid.
- DIV 10÷0, unit raises exception → md_ctrl_DIV pulse only (md_ctrl_MULT never high); out_rd=30, out_result=5.
- Stale ready: hold md_resultRDY=1 in ISSUE and the first BUSY cycle → ignored; completion only on the later qualified ready.
- flush at BUSY cycle 5 → IDLE next cycle, no out_valid, stall low; an immediately following MULT 3×3 completes with 9.
- reset asserted mid-BUSY, then released → all outputs 0, state IDLE; a unit ready arriving later produces no out_valid.
